dot_ram_write_arbiter: RTL and testbench

- Owns the write port of the 64-entry x 16-bit pixel RAM that feeds the 8x8 RGB dot-matrix scan driver.
- Arbitrates single-word writes from two requesters and one internal fill engine (full-frame clear/fill).
- Issues writes only inside the idle window between the scan driver's scan_done pulse and the next scan_en pulse, so RAM contents never change under an active row shift.

---
 rtl/dot_pkg.sv | 19 +
 rtl/dot_fill_engine.sv | 58 +++++
 rtl/dot_ram_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_dot_ram_write_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared constants and types for the dot-matrix pixel RAM write path.
// Pixel word layout is {1'b0, R[4:0], G[4:0], B[4:0]}.
package dot_pkg;

  localparam int ADDR_W  = 6;
  localparam int PIX_W   = 16;
  localparam int NUM_PIX = 64;

  localparam int PIX_B_LSB = 0;
  localparam int PIX_G_LSB = 5;
  localparam int PIX_R_LSB = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    FILL = 2'd2
  } state_t;

endpackage

// File: rtl/dot_fill_engine.sv
// Full-frame fill engine: captures the fill value, walks addresses 0..63 while
// allowed to advance, and reports busy/done to the arbiter.
module dot_fill_engine
  import dot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [PIX_W-1:0]  i_pixels,
  input  logic              i_advance,
  input  logic              i_pause,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_end,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [PIX_W-1:0]  o_pixels
);

  // One extra bit so the end of the frame is seen as 64 instead of wrapping to 0.
  logic [ADDR_W:0]    r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [PIX_W-1:0]   r_pix;
  logic               w_end;
  logic               w_wr;

  assign w_end    = r_busy && (r_cnt == (ADDR_W+1)'(NUM_PIX));
  assign w_wr     = r_busy && i_advance && !i_pause && !r_cnt[ADDR_W];

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_end    = w_end;
  assign o_wr     = w_wr;
  assign o_addr   = r_cnt[ADDR_W-1:0];
  assign o_pixels = r_pix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pix  <= '0;
    end else begin
      r_done <= w_end;
      if (!r_busy && i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_pix  <= i_pixels;
      end else if (w_end) begin
        r_busy <= 1'b0;
      end else if (w_wr) begin
        r_cnt <= r_cnt + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/dot_ram_write_arbiter.sv
// Write-port owner for the 64x16 pixel RAM: round-robin between two requesters
// and the fill engine, writing only in the idle window between scans.
module dot_ram_write_arbiter
  import dot_pkg::*;
#(
  parameter int MAX_WR = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic              scan_done,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [PIX_W-1:0]  data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [PIX_W-1:0]  data1,
  output logic              ack1,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_pixels,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              win_open,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [PIX_W-1:0]  ram_wr_pixels,
  output state_t            dbg_state
);

  localparam int BW = $clog2(MAX_WR + 1);

  // Requester handshake: req/addr/data are held until the registered ack
  // pulse; a req still high during the ack cycle is a fresh request.
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_win_open;
  logic               r_prio;
  logic [BW-1:0]      r_budget;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [PIX_W-1:0]   r_wr_pix;

  logic               w_open_evt;
  logic               w_can_grant;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_fill_accept;
  logic               w_fill_busy;
  logic               w_fill_done;
  logic               w_fill_end;
  logic               w_fill_wr;
  logic               w_fill_adv;
  logic [ADDR_W-1:0]  w_fill_addr;
  logic [PIX_W-1:0]   w_fill_pix;

  assign w_open_evt    = scan_done && !scan_en && !r_win_open;
  assign w_fill_accept = fill_start && !w_fill_busy;
  assign w_fill_adv    = (r_state == FILL) && r_win_open;

  // scan_en in the decision cycle suppresses the grant; r_prio=1 favours req1.
  assign w_can_grant = (r_state == OPEN) && r_win_open && !scan_en &&
                       (r_budget < BW'(MAX_WR));
  assign w_gnt0 = w_can_grant && req0 && (!req1 || !r_prio);
  assign w_gnt1 = w_can_grant && req1 && (!req0 || r_prio);

  dot_fill_engine u_fill (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (fill_start),
    .i_pixels (fill_pixels),
    .i_advance(w_fill_adv),
    .i_pause  (scan_en),
    .o_busy   (w_fill_busy),
    .o_done   (w_fill_done),
    .o_end    (w_fill_end),
    .o_wr     (w_fill_wr),
    .o_addr   (w_fill_addr),
    .o_pixels (w_fill_pix)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_open_evt) w_state_nxt = (w_fill_busy || w_fill_accept) ? FILL : OPEN;
      OPEN: begin
        if (scan_en)            w_state_nxt = IDLE;
        else if (w_fill_accept) w_state_nxt = FILL;
      end
      FILL: begin
        if (scan_en)                        w_state_nxt = IDLE;
        else if (w_fill_end || !w_fill_busy) w_state_nxt = OPEN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_win_open <= 1'b0;
      r_prio     <= 1'b0;
      r_budget   <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_pix   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (scan_en)        r_win_open <= 1'b0;
      else if (scan_done) r_win_open <= 1'b1;
      if (w_open_evt)           r_budget <= '0;
      else if (w_gnt0 || w_gnt1) r_budget <= r_budget + BW'(1);
      if (w_gnt0)      r_prio <= 1'b1;
      else if (w_gnt1) r_prio <= 1'b0;
      r_ack0  <= w_gnt0;
      r_ack1  <= w_gnt1;
      r_wr_en <= w_gnt0 || w_gnt1 || w_fill_wr;
      if (w_fill_wr) begin
        r_wr_addr <= w_fill_addr;
        r_wr_pix  <= w_fill_pix;
      end else if (w_gnt0) begin
        r_wr_addr <= addr0;
        r_wr_pix  <= data0;
      end else if (w_gnt1) begin
        r_wr_addr <= addr1;
        r_wr_pix  <= data1;
      end
    end
  end

  assign ack0          = r_ack0;
  assign ack1          = r_ack1;
  assign fill_busy     = w_fill_busy;
  assign fill_done     = w_fill_done;
  assign win_open      = r_win_open;
  assign ram_wr_en     = r_wr_en;
  assign ram_wr_addr   = r_wr_addr;
  assign ram_wr_pixels = r_wr_pix;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_dot_ram_write_arbiter.sv
// Directed bench for dot_ram_write_arbiter: window gating, round robin, budget,
// fill pause/resume, coincident events and reset during a fill.
module tb_dot_ram_write_arbiter;
  import dot_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              scan_en, scan_done;
  logic              req0, req1, ack0, ack1;
  logic [ADDR_W-1:0] addr0, addr1, ram_wr_addr;
  logic [PIX_W-1:0]  data0, data1, fill_pixels, ram_wr_pixels;
  logic              fill_start, fill_busy, fill_done, win_open, ram_wr_en;
  state_t            dbg_state;

  int checks   = 0;
  int failures = 0;
  int acks;

  dot_ram_write_arbiter #(.MAX_WR(16)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .scan_done(scan_done),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .fill_start(fill_start), .fill_pixels(fill_pixels),
    .fill_busy(fill_busy), .fill_done(fill_done), .win_open(win_open),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_pixels(ram_wr_pixels), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b0; scan_done = 1'b0;
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;
    fill_start = 1'b0; fill_pixels = '0;
    repeat (3) tick();
    chk("reset_outs", 32'({ack0, ack1, fill_busy, fill_done, win_open, ram_wr_en,
                           ram_wr_addr, ram_wr_pixels}), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Window gating
    req0 = 1'b1; addr0 = 6'd5; data0 = 16'h0401;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("closed_no_wr", 32'({win_open, ram_wr_en, ack0}), 32'd0);
    end
    scan_done = 1'b1; tick(); scan_done = 1'b0;
    chk("gate_win_open", 32'(win_open), 32'd1);
    chk("gate_no_wr_yet", 32'(ram_wr_en), 32'd0);
    tick();
    chk("gate_wr", 32'({ram_wr_en, ack0, ack1, ram_wr_addr, ram_wr_pixels}),
        32'({1'b1, 1'b1, 1'b0, 6'd5, 16'h0401}));
    req0 = 1'b0; tick();
    chk("gate_one_shot", 32'({ram_wr_en, ack0}), 32'd0);

    // Single req1 write so the round-robin pointer now favours req0
    req1 = 1'b1; addr1 = 6'd30; data1 = 16'h0033; tick();
    chk("r1_wr", 32'({ram_wr_en, ack0, ack1, ram_wr_addr, ram_wr_pixels}),
        32'({1'b1, 1'b0, 1'b1, 6'd30, 16'h0033}));
    req1 = 1'b0; tick();

    // Round robin: expected order 0,1,0,1
    req0 = 1'b1; addr0 = 6'd10; data0 = 16'h1111;
    req1 = 1'b1; addr1 = 6'd20; data1 = 16'h2222;
    tick();
    chk("rr0", 32'({ack0, ack1, ram_wr_en, ram_wr_addr, ram_wr_pixels}),
        32'({1'b1, 1'b0, 1'b1, 6'd10, 16'h1111}));
    addr0 = 6'd11; data0 = 16'h1112; tick();
    chk("rr1", 32'({ack0, ack1, ram_wr_en, ram_wr_addr, ram_wr_pixels}),
        32'({1'b0, 1'b1, 1'b1, 6'd20, 16'h2222}));
    addr1 = 6'd21; data1 = 16'h2223; tick();
    chk("rr2", 32'({ack0, ack1, ram_wr_en, ram_wr_addr, ram_wr_pixels}),
        32'({1'b1, 1'b0, 1'b1, 6'd11, 16'h1112}));
    req0 = 1'b0; tick();
    chk("rr3", 32'({ack0, ack1, ram_wr_en, ram_wr_addr, ram_wr_pixels}),
        32'({1'b0, 1'b1, 1'b1, 6'd21, 16'h2223}));
    req1 = 1'b0; tick();
    chk("rr_idle", 32'(ram_wr_en), 32'd0);

    // Budget: fresh window, req0 with distinct addresses 40.. and data 5000..
    scan_en = 1'b1; tick(); scan_en = 1'b0;
    chk("bud_closed", 32'(win_open), 32'd0);
    scan_done = 1'b1; tick(); scan_done = 1'b0;
    chk("bud_open", 32'(win_open), 32'd1);
    acks = 0;
    req0 = 1'b1; addr0 = 6'd40; data0 = 16'h5000;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (ack0) begin
        chk("bud_wr", 32'({ram_wr_addr, ram_wr_pixels}),
            32'({6'(40 + acks), 16'h5000 + 16'(acks)}));
        acks++;
        addr0 = 6'(40 + acks); data0 = 16'h5000 + 16'(acks);
      end
    end
    chk("bud_ack_count", 32'(acks), 32'd16);
    chk("bud_stalled", 32'(ram_wr_en), 32'd0);
    scan_en = 1'b1; tick(); scan_en = 1'b0;
    chk("bud_no_ack_closed", 32'(ack0), 32'd0);
    scan_done = 1'b1; tick(); scan_done = 1'b0;
    chk("bud_open_no_ack", 32'(ack0), 32'd0);
    tick();
    chk("bud_17th", 32'({ack0, ram_wr_en, ram_wr_addr, ram_wr_pixels}),
        32'({1'b1, 1'b1, 6'd56, 16'h5010}));
    req0 = 1'b0; tick();
    chk("bud_done", 32'(ram_wr_en), 32'd0);

    // Fill with pause after 40 writes
    fill_start = 1'b1; fill_pixels = 16'h7FFF; tick(); fill_start = 1'b0;
    chk("fill_busy_on", 32'({fill_busy, fill_done}), 32'({1'b1, 1'b0}));
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("fill_wr_a", 32'({ram_wr_en, ram_wr_addr, ram_wr_pixels}),
          32'({1'b1, 6'(i), 16'h7FFF}));
    end
    scan_en = 1'b1; tick(); scan_en = 1'b0;
    chk("fill_paused", 32'({win_open, ram_wr_en, fill_busy}), 32'({1'b0, 1'b0, 1'b1}));
    // Coincident scan_en/scan_done keeps the window closed
    scan_en = 1'b1; scan_done = 1'b1; tick(); scan_en = 1'b0; scan_done = 1'b0;
    chk("coinc_closed", 32'({win_open, ram_wr_en}), 32'd0);
    // fill_start while busy is ignored
    fill_start = 1'b1; fill_pixels = 16'h1234; tick(); fill_start = 1'b0;
    chk("ign_start", 32'({fill_busy, fill_done, ram_wr_en}), 32'({1'b1, 1'b0, 1'b0}));
    scan_done = 1'b1; tick(); scan_done = 1'b0;
    chk("fill_reopen", 32'({win_open, ram_wr_en}), 32'({1'b1, 1'b0}));
    for (int i = 40; i < 64; i++) begin
      tick();
      chk("fill_wr_b", 32'({ram_wr_en, ram_wr_addr, ram_wr_pixels, fill_done}),
          32'({1'b1, 6'(i), 16'h7FFF, 1'b0}));
    end
    tick();
    chk("fill_done", 32'({fill_done, fill_busy, ram_wr_en}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    chk("fill_done_pulse", 32'(fill_done), 32'd0);

    // Reset in the middle of a fill
    fill_start = 1'b1; fill_pixels = 16'h0421; tick(); fill_start = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      tick();
      chk("rfill_wr", 32'({ram_wr_en, ram_wr_addr, ram_wr_pixels}),
          32'({1'b1, 6'(i), 16'h0421}));
    end
    rst_n = 1'b0; tick();
    chk("rst_mid_outs", 32'({ack0, ack1, fill_busy, fill_done, win_open, ram_wr_en,
                             ram_wr_addr, ram_wr_pixels}), 32'd0);
    tick(); rst_n = 1'b1;
    req0 = 1'b1; addr0 = 6'd7; data0 = 16'h0707;
    req1 = 1'b1; addr1 = 6'd8; data1 = 16'h0808;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", 32'({fill_busy, fill_done, win_open, ram_wr_en, ack0, ack1}), 32'd0);
    end
    scan_done = 1'b1; tick(); scan_done = 1'b0;
    chk("post_rst_open", 32'({win_open, ram_wr_en}), 32'({1'b1, 1'b0}));
    tick();
    chk("post_rst_rr0", 32'({ack0, ack1, ram_wr_addr, ram_wr_pixels}),
        32'({1'b1, 1'b0, 6'd7, 16'h0707}));
    req0 = 1'b0; tick();
    chk("post_rst_rr1", 32'({ack0, ack1, ram_wr_addr, ram_wr_pixels}),
        32'({1'b0, 1'b1, 6'd8, 16'h0808}));
    req1 = 1'b0; tick();
    chk("post_rst_idle", 32'(ram_wr_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
